// File: rtl/synth_step_sequencer.sv
// Pattern step sequencer: plays an 8-slot note/rest pattern at a programmable tempo,
// emitting one note, one gate window and one step strobe per step for the synth voice.
module synth_step_sequencer #(
  parameter int STEPS  = 8,
  parameter int NOTE_W = 7,
  parameter int TIME_W = 16,
  localparam int AW    = $clog2(STEPS),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              run,
  input  logic [TIME_W-1:0] tempo,
  input  logic [TIME_W-1:0] gate_len,
  input  logic [LW-1:0]     length,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic              wr_rest,
  output logic [NOTE_W-1:0] note_out,
  output logic              gate_out,
  output logic [AW-1:0]     step_idx,
  output logic              step_pulse,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_ON  = 2'd1,
    GATE_OFF = 2'd2
  } state_t;

  state_t              state_q;
  logic                start_q;
  logic [NOTE_W-1:0]   note_q;
  logic                gate_q;
  logic [AW-1:0]       idx_q;
  logic                pulse_q;
  logic [TIME_W-1:0]   timer_q;
  logic [NOTE_W-1:0]   pat_note_q [STEPS];
  logic                pat_rest_q [STEPS];

  logic [TIME_W-1:0]   t_eff;
  logic [TIME_W-1:0]   g_raw;
  logic [TIME_W-1:0]   g_eff;
  logic [LW-1:0]       l_eff;
  logic [LW-1:0]       inc;
  logic [AW-1:0]       step_d;
  logic                go_step;
  logic                go_stop;
  logic                gate_drop;

  // Thresholds are compared live with >= so a shortened tempo or gate takes effect next cycle.
  always_comb begin
    t_eff     = (tempo < TIME_W'(2)) ? TIME_W'(2) : tempo;
    g_raw     = (gate_len == '0) ? TIME_W'(1) : gate_len;
    g_eff     = (g_raw > t_eff - TIME_W'(1)) ? t_eff - TIME_W'(1) : g_raw;
    l_eff     = (length == '0 || length > LW'(STEPS)) ? LW'(STEPS) : length;
    inc       = LW'(idx_q) + LW'(1);
    step_d    = '0;
    go_step   = 1'b0;
    go_stop   = 1'b0;
    gate_drop = 1'b0;
    if (state_q == IDLE) begin
      go_step = start_q;
    end else begin
      if (inc < l_eff) step_d = inc[AW-1:0];
      if (!run) go_stop = 1'b1;
      else if (timer_q >= t_eff) go_step = 1'b1;
      else if (state_q == GATE_ON && timer_q >= g_eff) gate_drop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      note_q  <= '0;
      gate_q  <= 1'b0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      timer_q <= '0;
      for (int i = 0; i < STEPS; i++) begin
        pat_note_q[i] <= '0;
        pat_rest_q[i] <= 1'b1;
      end
    end else if (ena) begin
      pulse_q <= 1'b0;
      // The slot read below sees the pre-write contents when write and entry coincide.
      if (wr_en) begin
        pat_note_q[wr_addr] <= wr_note;
        pat_rest_q[wr_addr] <= wr_rest;
      end
      if (go_step) begin
        state_q <= GATE_ON;
        start_q <= 1'b0;
        idx_q   <= step_d;
        if (!pat_rest_q[step_d]) note_q <= pat_note_q[step_d];
        gate_q  <= !pat_rest_q[step_d];
        pulse_q <= 1'b1;
        timer_q <= TIME_W'(1);
      end else if (state_q == IDLE || go_stop) begin
        state_q <= IDLE;
        start_q <= (state_q == IDLE) ? run : 1'b0;
        gate_q  <= 1'b0;
        idx_q   <= '0;
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TIME_W'(1);
        if (gate_drop) begin
          gate_q  <= 1'b0;
          state_q <= GATE_OFF;
        end
      end
    end
  end

  assign note_out   = note_q;
  assign gate_out   = gate_q;
  assign step_idx   = idx_q;
  assign step_pulse = pulse_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_synth_step_sequencer.sv
// Bench for synth_step_sequencer: directed scenarios plus randomized traffic checked
// against a phase-counting behavioural model of the step sequencer.
module tb_synth_step_sequencer;
  localparam int STEPS  = 8;
  localparam int NOTE_W = 7;
  localparam int TIME_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic              run = 1'b0;
  logic [TIME_W-1:0] tempo = 16'd10;
  logic [TIME_W-1:0] gate_len = 16'd6;
  logic [3:0]        length = 4'd4;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_addr = '0;
  logic [NOTE_W-1:0] wr_note = '0;
  logic              wr_rest = 1'b0;
  logic [NOTE_W-1:0] note_out;
  logic              gate_out;
  logic [2:0]        step_idx;
  logic              step_pulse;
  logic [1:0]        dbg_state;
  logic [11:0]       obs;

  synth_step_sequencer #(.STEPS(STEPS), .NOTE_W(NOTE_W), .TIME_W(TIME_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .tempo(tempo), .gate_len(gate_len),
    .length(length), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_rest(wr_rest),
    .note_out(note_out), .gate_out(gate_out), .step_idx(step_idx), .step_pulse(step_pulse),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  assign obs = {note_out, gate_out, step_idx, step_pulse};

  // Reference model: a step lasts T clocks; phase counts clocks since the step began.
  int  m_pat_note [STEPS];
  bit  m_pat_rest [STEPS];
  bit  m_playing, m_arm, m_sounding, m_gate, m_pulse;
  int  m_idx, m_phase, m_note;
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  logic [NOTE_W-1:0] exp_q [$];

  function automatic logic [11:0] exp_vec();
    return {NOTE_W'(m_note), m_gate, 3'(m_idx), m_pulse};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < STEPS; i++) begin
      m_pat_note[i] = 0;
      m_pat_rest[i] = 1'b1;
    end
    m_playing = 0; m_arm = 0; m_sounding = 0; m_gate = 0; m_pulse = 0;
    m_idx = 0; m_phase = 0; m_note = 0;
  endtask

  task automatic model_enter(input int s);
    m_playing  = 1;
    m_idx      = s;
    if (!m_pat_rest[s]) m_note = m_pat_note[s];
    m_sounding = !m_pat_rest[s];
    m_gate     = m_sounding;
    m_pulse    = 1;
    m_phase    = 0;
  endtask

  task automatic model_edge();
    int t, g, l;
    if (!ena) return;
    t = (tempo < 2) ? 2 : int'(tempo);
    g = (gate_len == 0) ? 1 : int'(gate_len);
    if (g > t - 1) g = t - 1;
    l = (length == 0 || length > STEPS) ? STEPS : int'(length);
    m_pulse = 0;
    if (!m_playing) begin
      m_gate = 0;
      m_idx  = 0;
      if (m_arm) begin
        model_enter(0);
        m_arm = 0;
      end else begin
        m_arm = run;
      end
    end else if (!run) begin
      m_playing = 0; m_gate = 0; m_idx = 0; m_arm = 0;
    end else begin
      m_phase++;
      if (m_phase >= t) model_enter((m_idx + 1 >= l) ? 0 : m_idx + 1);
      else m_gate = m_sounding && (m_phase < g);
    end
    if (wr_en) begin
      m_pat_note[wr_addr] = wr_note;
      m_pat_rest[wr_addr] = wr_rest;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic write_slot(input int a, input int n, input bit r);
    wr_en = 1'b1; wr_addr = 3'(a); wr_note = NOTE_W'(n); wr_rest = r;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_basic();
    write_slot(0, 60, 0);
    write_slot(1, 62, 0);
    write_slot(2, 64, 0);
    write_slot(3, 65, 0);
    for (int i = 4; i < STEPS; i++) write_slot(i, $urandom_range(0, 127), 1'($urandom_range(0, 1)));
  endtask

  task automatic stop_run();
    run = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #12;
    if (obs !== 12'h000 || dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h/%0d expected 000/0", obs, dbg_state);
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle: got %h expected %h", obs, exp_vec()); end
      n_cmp++;
    end
  endtask

  task automatic test_basic();
    int last = -1, np = 0, hi = 0;
    logic [NOTE_W-1:0] e;
    load_basic();
    tempo = 10; gate_len = 6; length = 4; run = 1'b1;
    exp_q = {7'd60, 7'd62, 7'd64, 7'd65, 7'd60};
    for (int i = 0; i < 52; i++) begin
      tick();
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL basic_model c%0d: got %h expected %h", cyc, obs, exp_vec()); end
      n_cmp++;
      if (step_pulse) begin
        np++;
        if (last >= 0) begin
          if (cyc - last !== 10) begin n_bad++; $display("FAIL basic_period: got %0d expected 10", cyc - last); end
          n_cmp++;
        end
        last = cyc;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (note_out !== e) begin n_bad++; $display("FAIL basic_note: got %0d expected %0d", note_out, e); end
          n_cmp++;
        end
        if (np == 5) begin
          if (step_idx !== 3'd0) begin n_bad++; $display("FAIL basic_wrap: got %0d expected 0", step_idx); end
          n_cmp++;
        end
      end
      if (np >= 1 && np <= 4 && gate_out) hi++;
    end
    if (hi !== 24 || np < 5) begin n_bad++; $display("FAIL basic_gate_hi: got %0d/%0d expected 24/>=5", hi, np); end
    n_cmp++;
    stop_run();
  endtask

  task automatic test_rest();
    int seen = 0;
    write_slot(1, 99, 1);
    run = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rest_model c%0d: got %h expected %h", cyc, obs, exp_vec()); end
      n_cmp++;
      if (dbg_state != 2'd0 && step_idx == 3'd1) begin
        if (step_pulse) seen++;
        if (gate_out !== 1'b0 || note_out !== 7'd60) begin
          n_bad++; $display("FAIL rest_step: got gate=%0b note=%0d expected gate=0 note=60", gate_out, note_out);
        end
        n_cmp++;
      end
    end
    if (seen < 1) begin n_bad++; $display("FAIL rest_pulse: got %0d expected >=1", seen); end
    n_cmp++;
    stop_run();
    write_slot(1, 62, 0);
  endtask

  task automatic test_clamp();
    int last, hi;
    for (int pass = 0; pass < 2; pass++) begin
      tempo    = (pass == 0) ? 16'd1 : 16'd10;
      gate_len = (pass == 0) ? 16'd50 : 16'd0;
      run = 1'b1; last = -1; hi = 0;
      for (int i = 0; i < ((pass == 0) ? 16 : 40); i++) begin
        tick();
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL clamp_model c%0d: got %h expected %h", cyc, obs, exp_vec()); end
        n_cmp++;
        if (step_pulse) begin
          if (last >= 0) begin
            if (cyc - last !== ((pass == 0) ? 2 : 10) || hi !== 1) begin
              n_bad++; $display("FAIL clamp_step p%0d: got period=%0d hi=%0d expected period=%0d hi=1",
                                pass, cyc - last, hi, (pass == 0) ? 2 : 10);
            end
            n_cmp++;
          end
          last = cyc; hi = 0;
        end
        if (gate_out) hi++;
      end
      stop_run();
    end
    tempo = 10; gate_len = 6;
  endtask

  task automatic test_write();
    int guard = 0;
    logic [NOTE_W-1:0] e;
    run = 1'b1;
    while (!(step_pulse && step_idx == 3'd2) && guard < 60) begin tick(); guard++; end
    if (guard >= 60) begin n_bad++; $display("FAIL write_wait: got timeout expected step 2"); end
    n_cmp++;
    write_slot(2, 72, 0);
    write_slot(3, 48, 0);
    exp_q = {7'd48, 7'd60, 7'd62, 7'd72};
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL write_model c%0d: got %h expected %h", cyc, obs, exp_vec()); end
      n_cmp++;
      if (step_idx == 3'd2 && exp_q.size() == 4) begin
        if (note_out !== 7'd64) begin n_bad++; $display("FAIL write_midstep: got %0d expected 64", note_out); end
        n_cmp++;
      end
      tick(); guard++;
      if (step_pulse) begin
        e = exp_q.pop_front();
        if (note_out !== e) begin n_bad++; $display("FAIL write_note: got %0d expected %0d", note_out, e); end
        n_cmp++;
      end
    end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL write_timeout: got %0d left expected 0", exp_q.size()); end
    n_cmp++;
    stop_run();
    write_slot(2, 64, 0);
    write_slot(3, 65, 0);
  endtask

  task automatic test_stop_restart();
    int guard = 0;
    run = 1'b1;
    while (!(step_pulse && step_idx == 3'd2) && guard < 60) begin tick(); guard++; end
    if (guard >= 60) begin n_bad++; $display("FAIL stop_wait: got timeout expected step 2"); end
    n_cmp++;
    tick(); tick();
    run = 1'b0;
    tick();
    if (gate_out !== 1'b0 || step_idx !== 3'd0 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL stop_next: got gate=%0b idx=%0d (%h) expected gate=0 idx=0 (%h)", gate_out, step_idx, obs, exp_vec());
    end
    n_cmp++;
    tick(); tick();
    run = 1'b1;
    tick();
    if (step_pulse !== 1'b0) begin n_bad++; $display("FAIL restart_early: got pulse=%0b expected 0", step_pulse); end
    n_cmp++;
    tick();
    if (step_pulse !== 1'b1 || step_idx !== 3'd0 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL restart_step0: got pulse=%0b idx=%0d expected pulse=1 idx=0", step_pulse, step_idx);
    end
    n_cmp++;
  endtask

  task automatic test_freeze_reset();
    int guard = 0, last, np = 0;
    logic [11:0] snap;
    while (!step_pulse && guard < 20) begin tick(); guard++; end
    last = cyc;
    tick(); tick();
    snap = obs;
    ena = 1'b0;
    repeat (7) begin
      tick();
      if (obs !== snap || dbg_state == 2'd0) begin n_bad++; $display("FAIL freeze_hold: got %h expected %h", obs, snap); end
      n_cmp++;
    end
    ena = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (!step_pulse && guard < 40);
    if (cyc - last !== 17) begin n_bad++; $display("FAIL freeze_period: got %0d expected 17", cyc - last); end
    n_cmp++;
    tick(); tick();
    #2 rst_n = 1'b0; run = 1'b0;
    #1;
    if (obs !== 12'h000 || dbg_state !== 2'd0) begin
      n_bad++; $display("FAIL async_reset: got %h/%0d expected 000/0", obs, dbg_state);
    end
    n_cmp++;
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    length = 0; tempo = 4; gate_len = 2; run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step_pulse) np++;
      if (gate_out !== 1'b0 || obs !== exp_vec()) begin
        n_bad++; $display("FAIL cleared_pattern c%0d: got %h expected %h", cyc, obs, exp_vec());
      end
      n_cmp++;
    end
    if (np < 8) begin n_bad++; $display("FAIL cleared_loop: got %0d pulses expected >=8", np); end
    n_cmp++;
    stop_run();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (!run && !m_playing && $urandom_range(0, 3) == 0) begin
        tempo    = TIME_W'($urandom_range(0, 9));
        gate_len = TIME_W'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 24) == 0) run = ~run;
      if ($urandom_range(0, 39) == 0) length = 4'($urandom_range(0, 15));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_note = NOTE_W'($urandom_range(0, 127));
      wr_rest = ($urandom_range(0, 3) == 0);
      ena     = ($urandom_range(0, 7) != 0);
      tick();
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL random c%0d: got %h expected %h", cyc, obs, exp_vec()); end
      n_cmp++;
    end
    wr_en = 1'b0; ena = 1'b1;
    stop_run();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_rest();
    test_clamp();
    test_write();
    test_stop_restart();
    test_freeze_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
